line_cmd_queue: RTL and testbench

Command front-end for the line drawer. Buffers line and screen-clear commands from the game/host logic in a small FIFO and sequences them one at a time into the drawer's start/clear/x0/y0/x1/y1/done handshake. Endpoint coordinates are clamped to the visible area, and operands are held stable for the drawer's whole operation. Sits directly upstream of the line drawer; the drawer's x/y/colour outputs go straight to the framebuffer.

---
 rtl/line_cmd_queue_pkg.sv | 36 +++
 rtl/line_cmd_queue_if.sv | 39 +++
 rtl/line_cmd_queue_fifo.sv | 58 +++++
 rtl/line_cmd_queue.sv | 120 ++++++++++++
 tb/tb_line_cmd_queue.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_cmd_queue_pkg.sv
// Shared types for the line drawer command front-end:
// screen bounds, the queued command record, FSM state codes, clamp helper.
package line_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COORD_W  = 11;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic   clear;
      coord_t x0;
      coord_t y0;
      coord_t x1;
      coord_t y1;
   } line_cmd_t;

   // FSM state encoding, kept as plain constants
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_RUN     = 2'd1;
   localparam state_t ST_RELEASE = 2'd2;

   // Saturate an unsigned coordinate to lim-1
   function automatic coord_t clamp(input coord_t v,
                                    input int     lim);
      coord_t bound;
      coord_t top;
      bound = coord_t'(lim);
      top   = coord_t'(lim - 1);
      return (v >= bound) ? top : v;
   endfunction

endpackage

// File: rtl/line_cmd_queue_if.sv
// Command and drawer handshake bundle for line_cmd_queue.
// slave: queue side; master: host + drawer side.
interface line_cmd_queue_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_clear;
   logic [10:0] cmd_x0;
   logic [10:0] cmd_y0;
   logic [10:0] cmd_x1;
   logic [10:0] cmd_y1;

   logic        ld_start;
   logic        ld_clear;
   logic [10:0] ld_x0;
   logic [10:0] ld_y0;
   logic [10:0] ld_x1;
   logic [10:0] ld_y1;
   logic        ld_done;

   modport slave (
      input  cmd_valid, cmd_clear,
      input  cmd_x0, cmd_y0, cmd_x1, cmd_y1,
      output cmd_ready,
      output ld_start, ld_clear,
      output ld_x0, ld_y0, ld_x1, ld_y1,
      input  ld_done
   );

   modport master (
      output cmd_valid, cmd_clear,
      output cmd_x0, cmd_y0, cmd_x1, cmd_y1,
      input  cmd_ready,
      input  ld_start, ld_clear,
      input  ld_x0, ld_y0, ld_x1, ld_y1,
      output ld_done
   );

endinterface

// File: rtl/line_cmd_queue_fifo.sv
// Generic synchronous FIFO: register array, wrap-around pointers.
// Ports: push/din, pop/dout, full, empty, count.
module cmd_fifo #(
   parameter  int W     = 45,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = mem[rp];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push)
            wp <= wp + 1'b1;
         if (do_pop)
            rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wp] <= din;
   end

endmodule

// File: rtl/line_cmd_queue.sv
// Line drawer command front-end: FIFO + start/done sequencer with clamp.
// Ports: clk, reset, bus (slave), busy, count, lines_done.
module line_cmd_queue
   import line_pkg::*;
#(
   parameter  int WIDTH  = SCREEN_W,
   parameter  int HEIGHT = SCREEN_H,
   parameter  int DEPTH  = 8,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   line_cmd_queue_if.slave  bus,
   output logic             busy,
   output logic [CW-1:0]    count,
   output logic [15:0]      lines_done
);

   line_cmd_t in_cmd;
   line_cmd_t head;
   logic      full;
   logic      empty;
   logic      pop;
   state_t    state;

   logic      start_q;
   logic      clear_q;
   coord_t    x0_q;
   coord_t    y0_q;
   coord_t    x1_q;
   coord_t    y1_q;

   assign in_cmd = '{
      clear: bus.cmd_clear,
      x0:    bus.cmd_x0,
      y0:    bus.cmd_y0,
      x1:    bus.cmd_x1,
      y1:    bus.cmd_y1
   };

   assign pop = (state == ST_IDLE) & ~empty;

   cmd_fifo #(
      .W     ($bits(line_cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.cmd_valid),
      .din   (in_cmd),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.cmd_ready = ~full;
   assign busy          = (state != ST_IDLE);

   assign bus.ld_start  = start_q;
   assign bus.ld_clear  = clear_q;
   assign bus.ld_x0     = x0_q;
   assign bus.ld_y0     = y0_q;
   assign bus.ld_x1     = x1_q;
   assign bus.ld_y1     = y1_q;

   // Operands load only at the pop edge, so they hold
   // through RUN and RELEASE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         start_q    <= 1'b0;
         clear_q    <= 1'b0;
         x0_q       <= '0;
         y0_q       <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         lines_done <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  clear_q <= head.clear;
                  if (head.clear) begin
                     x0_q <= '0;
                     y0_q <= '0;
                     x1_q <= '0;
                     y1_q <= '0;
                  end else begin
                     x0_q <= clamp(head.x0, WIDTH);
                     y0_q <= clamp(head.y0, HEIGHT);
                     x1_q <= clamp(head.x1, WIDTH);
                     y1_q <= clamp(head.y1, HEIGHT);
                  end
                  start_q <= 1'b1;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.ld_done) begin
                  start_q    <= 1'b0;
                  lines_done <= lines_done + 16'd1;
                  state      <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               // wait for the drawer to drop done
               if (!bus.ld_done)
                  state <= ST_IDLE;
            end
            default: begin
               start_q <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_cmd_queue.sv
// Directed bench for line_cmd_queue with a behavioural drawer model.
// Table of clamp/clear vectors plus hand-written corner sequences.
module tb_line_cmd_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [3:0]  count;
   logic [15:0] lines_done;

   always #10 clk = ~clk;

   line_cmd_queue_if bus ();

   line_cmd_queue #(
      .WIDTH  (320),
      .HEIGHT (240),
      .DEPTH  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .busy       (busy),
      .count      (count),
      .lines_done (lines_done)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drawer model: done after lat start-cycles,
   // dropped hold cycles after start is seen low
   int   lat  = 4;
   int   hold = 1;
   int   m_cnt = 0;
   int   m_hold = 0;
   logic m_done = 1'b0;
   logic man_mode = 1'b0;
   logic man_done = 1'b0;

   assign bus.ld_done = man_mode ? man_done : m_done;

   always @(posedge clk) begin
      if (reset) begin
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_hold <= 0;
      end else if (!m_done) begin
         m_hold <= 0;
         if (bus.ld_start) begin
            if (m_cnt + 1 >= lat) begin
               m_done <= 1'b1;
               m_cnt  <= 0;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end else begin
            m_cnt <= 0;
         end
      end else if (!bus.ld_start) begin
         if (m_hold + 1 >= hold) begin
            m_done <= 1'b0;
            m_hold <= 0;
         end else begin
            m_hold <= m_hold + 1;
         end
      end
   end

   // start-rise monitor for the spacing test
   logic        mon_en = 1'b0;
   logic        prev_s = 1'b0;
   int          k = 0;
   logic [10:0] exp_order [3];

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.ld_start && !prev_s) begin
            chk("start_vs_done", bus.ld_done, 0);
            if (k < 3)
               chk("order", bus.ld_x0, exp_order[k]);
            k++;
         end
         prev_s = bus.ld_start;
      end
   end

   task automatic drive(input logic c,
                        input logic [10:0] a, b, d, e);
      bus.cmd_clear = c;
      bus.cmd_x0    = a;
      bus.cmd_y0    = b;
      bus.cmd_x1    = d;
      bus.cmd_y1    = e;
   endtask

   task automatic push1(input logic c,
                        input logic [10:0] a, b, d, e);
      drive(c, a, b, d, e);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (!busy && count == 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   typedef struct {
      logic        clr;
      logic [10:0] x0, y0, x1, y1;
      logic        eclr;
      logic [10:0] ex0, ey0, ex1, ey1;
   } vec_t;

   vec_t vt [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit bad;
      int t;
      int acc;

      vt[0] = '{1'b0, 500, 10, 2047, 300, 1'b0, 319, 10, 319, 239};
      vt[1] = '{1'b1, 5, 5, 6, 6,         1'b1, 0, 0, 0, 0};
      vt[2] = '{1'b0, 10, 20, 40, 25,     1'b0, 10, 20, 40, 25};
      vt[3] = '{1'b0, 319, 239, 320, 240, 1'b0, 319, 239, 319, 239};
      vt[4] = '{1'b0, 0, 0, 0, 0,         1'b0, 0, 0, 0, 0};

      reset = 1'b1;
      bus.cmd_valid = 1'b0;
      drive(1'b0, 0, 0, 0, 0);
      step();
      step();
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_lines", lines_done, 0);
      chk("rst_ld", {bus.ld_start, bus.ld_clear, bus.ld_x0,
                     bus.ld_y0, bus.ld_x1, bus.ld_y1}, 0);
      reset = 1'b0;
      step();

      // single line, 30-cycle drawer
      lat = 30;
      push1(1'b0, 10, 20, 40, 25);
      chk("single_count", count, 1);
      chk("single_nostart", bus.ld_start, 0);
      step();
      chk("single_start", bus.ld_start, 1);
      bad = 1'b0;
      t = 0;
      while (bus.ld_done !== 1'b1 && t < 100) begin
         if (bus.ld_x1 !== 11'd40 || bus.ld_y1 !== 11'd25)
            bad = 1'b1;
         step();
         t++;
      end
      chk("single_done_seen", t < 100, 1);
      chk("single_stable", bad, 0);
      step();
      chk("single_start_low", bus.ld_start, 0);
      chk("single_lines", lines_done, 1);
      wait_idle(20, ok);
      chk("single_idle", ok, 1);
      chk("single_busy", busy, 0);

      // clamp / clear table
      lat = 4;
      for (int i = 0; i < 5; i++) begin
         push1(vt[i].clr, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1);
         chk("tbl_count", count, 1);
         step();
         chk("tbl_start", bus.ld_start, 1);
         chk($sformatf("tbl_payload%0d", i),
             {bus.ld_clear, bus.ld_x0, bus.ld_y0,
              bus.ld_x1, bus.ld_y1},
             {vt[i].eclr, vt[i].ex0, vt[i].ey0,
              vt[i].ex1, vt[i].ey1});
         wait_idle(50, ok);
         chk("tbl_idle", ok, 1);
         chk("tbl_lines", lines_done, 2 + i);
      end

      // stale done in IDLE is ignored
      man_mode = 1'b1;
      man_done = 1'b1;
      step();
      step();
      step();
      chk("stale_busy", busy, 0);
      chk("stale_lines", lines_done, 6);
      man_done = 1'b0;
      man_mode = 1'b0;
      step();

      // handshake spacing with a long done hold
      hold = 3;
      exp_order[0] = 11;
      exp_order[1] = 12;
      exp_order[2] = 13;
      k = 0;
      prev_s = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 11'(11 + i), 5, 6, 7);
         bus.cmd_valid = 1'b1;
         step();
      end
      bus.cmd_valid = 1'b0;
      wait_idle(300, ok);
      step();
      mon_en = 1'b0;
      chk("space_idle", ok, 1);
      chk("space_starts", k, 3);
      chk("space_lines", lines_done, 9);
      hold = 1;

      // full queue with the drawer stalled
      man_mode = 1'b1;
      man_done = 1'b0;
      push1(1'b0, 50, 1, 2, 3);
      step();
      chk("full_first_start", bus.ld_start, 1);
      acc = 0;
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 11'(60 + i), 1, 2, 3);
         bus.cmd_valid = 1'b1;
         if (bus.cmd_ready)
            acc++;
         step();
      end
      bus.cmd_valid = 1'b0;
      chk("full_accepted", acc, 8);
      chk("full_count", count, 8);
      chk("full_ready", bus.cmd_ready, 0);
      man_done = 1'b1;
      step();
      man_done = 1'b0;
      chk("full_rel_start", bus.ld_start, 0);
      chk("full_rel_lines", lines_done, 10);
      step();
      drive(1'b0, 99, 1, 2, 3);
      bus.cmd_valid = 1'b1;
      step();
      chk("pop_count", count, 7);
      chk("pop_ready", bus.cmd_ready, 1);
      chk("pop_head", bus.ld_x0, 60);
      step();
      bus.cmd_valid = 1'b0;
      chk("refill_count", count, 8);
      chk("refill_ready", bus.cmd_ready, 0);

      // reset while RUN with a full queue
      chk("pre_rst_start", bus.ld_start, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      man_mode = 1'b0;
      chk("mid_rst_start", bus.ld_start, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_lines", lines_done, 0);
      chk("mid_rst_busy", busy, 0);
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.ld_start !== 1'b0 || busy !== 1'b0)
            bad = 1'b1;
         step();
      end
      chk("post_rst_quiet", bad, 0);
      push1(1'b0, 7, 8, 9, 10);
      step();
      chk("post_rst_start", bus.ld_start, 1);
      wait_idle(50, ok);
      chk("post_rst_idle", ok, 1);
      chk("post_rst_lines", lines_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
